match_arbiter: RTL and testbench
================================

// Module: match_arbiter
// PURPOSE
//  Collects per-note match events from the 37 note matchers and presents them one at a time
//  to the scoring unit over a valid/ready handshake. No event is lost when several notes match
//  in the same cycle. Each note has a one-entry pending slot; notes are granted round-robin.
//  Timing error dt is computed when an event is granted. Sits between the note matchers and the scorer.
// PARAMETERS
//  N_NOTES  37    number of note lanes / match requesters
//  TIME_W   16    width of song_time and per-note match timestamps
//  IDX_W    6     width of note index, >= clog2(N_NOTES)
//  MAX_AGE  16'd2000  pending events with |dt| > MAX_AGE at grant time are discarded as stale
// PORTS
//  clk            in   1                 system clock
//  rst            in   1                 synchronous, active-high reset
//  song_time      in   TIME_W            current song time, free-running, wraps at 2^TIME_W
//  match_trigger  in   N_NOTES           1-cycle pulse per note on a match
//  match_time     in   N_NOTES*TIME_W    note i target time in bits [i*TIME_W +: TIME_W]
//  score_ready    in   1                 scorer accepts the output this cycle
//  score_valid    out  1                 output event valid
//  score_note     out  IDX_W             note index of the presented event
//  score_dt       out  TIME_W            signed dt = song_time - target time, two's complement
//  drop_count     out  8                 saturating count of events lost to a full slot
//  stale_count    out  8                 saturating count of events discarded by the MAX_AGE check
// BEHAVIOUR
//  Reset (rst=1 at a clk edge): all pending bits=0, rr_ptr=0, score_valid=0, score_note=0,
//    score_dt=0, drop_count=0, stale_count=0. Inputs are ignored during that cycle.
//  Capture: if match_trigger[i]=1 and pending[i]=0 at edge, then on that edge pending[i]<=1
//    and ptime[i]<=match_time[i].
//  Full slot: if match_trigger[i]=1 and pending[i]=1, and the slot is not being granted that
//    cycle, the new event is dropped. ptime[i] is unchanged and drop_count increments,
//    saturating at 255. Multiple drops in one cycle add 1 only.
//  Output register: "load" is allowed when score_valid=0, or when score_valid=1 and score_ready=1.
//    If score_valid=1 and score_ready=0, all outputs hold stable and no grant occurs.
//  Grant: when load is allowed, select the first j with pending[j]=1, scanning
//    rr_ptr, rr_ptr+1, ..., N_NOTES-1, 0, ... (wrapping). Selection uses the registered
//    pending state, so the next edge of a new trigger is not visible yet.
//    On the edge: pending[j]<=0, rr_ptr<=(j+1) mod N_NOTES,
//    dt = (song_time - ptime[j]) mod 2^TIME_W, read as signed.
//    If |dt| <= MAX_AGE: score_valid<=1, score_note<=j, score_dt<=dt.
//    Otherwise: the event is discarded, stale_count increments (saturating at 255), and
//    score_valid<=0 for that cycle.
//    If no slot is pending: score_valid<=0 and rr_ptr is unchanged.
//    Exactly one grant occurs per cycle, at most.
//  Grant and trigger on the same note in the same cycle: the grant consumes the old ptime.
//    The new trigger then sets pending[j]<=1 with the new time; the set wins and it is not a drop.
//  Latency: trigger at edge k sets pending. With the output idle and no other pending slots,
//    score_valid=1 after edge k+1. Sustained throughput is 1 event/cycle while score_ready=1.
//  Wrap-around: dt is modular, so song_time=16'h0005 with ptime=16'hFFFE gives dt=+7.
//  dt is sampled at grant time. It does not update while the output is held.
//  Reset mid-operation: all pending events and the held output are discarded without being
//    reported. The counters clear.
// TESTING
//  1. Single event: rst, then trigger note 3 with time 100 while song_time=104 and score_ready=1
//     -> score_valid=1 two edges later, score_note=3, score_dt=+4, then score_valid=0.
//  2. Burst: triggers on notes 0, 5 and 36 in one cycle, rr_ptr=0, score_ready=1
//     -> three consecutive valid cycles with notes 0, 5, 36; drop_count=0.
//  3. Backpressure: hold score_ready=0 for 10 cycles with note 7 presented
//     -> outputs stable; a second trigger on note 7 makes drop_count=1; after release,
//     note 7 is output twice (held event, then the pending event).
//  4. Fairness: notes 1 and 2 retrigger every cycle after each grant
//     -> grants alternate 1, 2, 1, 2; neither note starves.
//  5. Wrap/stale: ptime=16'hFFFE with song_time=16'h0003 -> score_dt=5. ptime=0 with
//     song_time=3000 -> no valid output, stale_count=1.
//  6. Reset mid-burst: 4 notes pending, assert rst for 1 cycle
//     -> score_valid=0 and no further outputs; counters=0.

Source files
------------

// File: rtl/match_arbiter.sv
// Round-robin arbiter collecting per-note match events into one scorer stream.
// Ports: clk, rst, song_time, match_trigger, match_time in; score_* / counters out.
module match_arbiter #(
  parameter int                N_NOTES = 37,
  parameter int                TIME_W  = 16,
  parameter int                IDX_W   = 6,
  parameter logic [TIME_W-1:0] MAX_AGE = 16'd2000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [TIME_W-1:0]           song_time,
  input  logic [N_NOTES-1:0]          match_trigger,
  input  logic [N_NOTES*TIME_W-1:0]   match_time,
  input  logic                        score_ready,
  output logic                        score_valid,
  output logic [IDX_W-1:0]            score_note,
  output logic [TIME_W-1:0]           score_dt,
  output logic [7:0]                  drop_count,
  output logic [7:0]                  stale_count
);

  logic [N_NOTES-1:0] r_pending;
  logic [TIME_W-1:0]  r_ptime [N_NOTES];
  logic [IDX_W-1:0]   r_rr;
  logic               r_valid;
  logic [IDX_W-1:0]   r_note;
  logic [TIME_W-1:0]  r_dt;
  logic [7:0]         r_drop;
  logic [7:0]         r_stale;

  logic               w_load;
  logic               w_found;
  logic               w_grant;
  logic               w_fresh;
  logic               w_drop;
  logic [IDX_W:0]     w_idx;
  logic [IDX_W-1:0]   w_sel;
  logic [IDX_W-1:0]   w_next;
  logic [TIME_W-1:0]  w_dt;
  logic [TIME_W-1:0]  w_mag;
  logic [N_NOTES-1:0] w_hit;

  // Scan from r_rr upward with wrap; first pending slot wins.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 0; k < N_NOTES; k++) begin
      w_idx = {1'b0, r_rr} + (IDX_W+1)'(k);
      if (w_idx >= (IDX_W+1)'(N_NOTES))
        w_idx = w_idx - (IDX_W+1)'(N_NOTES);
      if (!w_found && r_pending[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[IDX_W-1:0];
      end
    end
  end

  assign w_load  = !r_valid || score_ready;
  assign w_grant = w_load && w_found;
  assign w_hit   = w_grant ? (N_NOTES'(1) << w_sel) : '0;

  // Modular difference; magnitude of 0x8000 stays 0x8000, which is stale.
  assign w_dt    = song_time - r_ptime[w_sel];
  assign w_mag   = w_dt[TIME_W-1] ? (~w_dt + TIME_W'(1)) : w_dt;
  assign w_fresh = (w_mag <= MAX_AGE);

  // A trigger on the slot being granted refills it and is not a drop.
  assign w_drop  = |(match_trigger & r_pending & ~w_hit);
  assign w_next  = (w_sel == IDX_W'(N_NOTES - 1)) ? '0 : w_sel + IDX_W'(1);

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_NOTES; i++) begin
      if (!rst && match_trigger[i] && (!r_pending[i] || w_hit[i]))
        r_ptime[i] <= match_time[i*TIME_W +: TIME_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
      r_rr      <= '0;
      r_valid   <= 1'b0;
      r_note    <= '0;
      r_dt      <= '0;
      r_drop    <= '0;
      r_stale   <= '0;
    end else begin
      r_pending <= (r_pending & ~w_hit) | match_trigger;
      if (w_drop && r_drop != 8'hFF)
        r_drop <= r_drop + 8'd1;
      if (w_load) begin
        r_valid <= 1'b0;
        if (w_grant) begin
          r_rr <= w_next;
          if (w_fresh) begin
            r_valid <= 1'b1;
            r_note  <= w_sel;
            r_dt    <= w_dt;
          end else if (r_stale != 8'hFF) begin
            r_stale <= r_stale + 8'd1;
          end
        end
      end
    end
  end

  assign score_valid = r_valid;
  assign score_note  = r_note;
  assign score_dt    = r_dt;
  assign drop_count  = r_drop;
  assign stale_count = r_stale;

endmodule

// File: tb/tb_match_arbiter.sv
// Scoreboard bench for match_arbiter.
// Expected events are queued at trigger time and popped on each handshake.
module tb_match_arbiter;

  localparam int N = 37;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [TW-1:0]   song_time;
  logic [N-1:0]    match_trigger;
  logic [N*TW-1:0] match_time;
  logic            score_ready;
  logic            score_valid;
  logic [5:0]      score_note;
  logic [TW-1:0]   score_dt;
  logic [7:0]      drop_count;
  logic [7:0]      stale_count;

  int n_pass = 0;
  int n_total = 0;
  logic [21:0] q[$];
  logic [21:0] e_exp;

  match_arbiter dut (
    .clk(clk),
    .rst(rst),
    .song_time(song_time),
    .match_trigger(match_trigger),
    .match_time(match_time),
    .score_ready(score_ready),
    .score_valid(score_valid),
    .score_note(score_note),
    .score_dt(score_dt),
    .drop_count(drop_count),
    .stale_count(stale_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_total++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mt(input int idx, input logic [TW-1:0] v);
    match_time[idx*TW +: TW] = v;
  endtask

  task automatic push(input logic [5:0] nt, input logic [TW-1:0] dt);
    q.push_back({nt, dt});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    match_trigger = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) step();
    check("drain", 32'(q.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && score_valid && score_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e_exp = q.pop_front();
        check("note", 32'(score_note), 32'(e_exp[21:16]));
        check("dt", 32'(score_dt), 32'(e_exp[15:0]));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    song_time = '0;
    match_trigger = '0;
    match_time = '0;
    score_ready = 1'b0;
    step();
    step();
    check("rst_valid", 32'(score_valid), 32'd0);
    check("rst_note", 32'(score_note), 32'd0);
    check("rst_dt", 32'(score_dt), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_stale", 32'(stale_count), 32'd0);
    rst = 1'b0;

    // single event
    score_ready = 1'b1;
    song_time = 16'd104;
    set_mt(3, 16'd100);
    match_trigger[3] = 1'b1;
    push(6'd3, 16'd4);
    step();
    match_trigger = '0;
    step();
    check("t1_valid", 32'(score_valid), 32'd1);
    step();
    check("t1_idle", 32'(score_valid), 32'd0);

    // burst of three in one cycle
    do_reset();
    song_time = 16'd1000;
    set_mt(0, 16'd1000);
    set_mt(5, 16'd990);
    set_mt(36, 16'd1010);
    match_trigger[0] = 1'b1;
    match_trigger[5] = 1'b1;
    match_trigger[36] = 1'b1;
    push(6'd0, 16'd0);
    push(6'd5, 16'd10);
    push(6'd36, 16'hFFF6);
    step();
    match_trigger = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_valid", 32'(score_valid), 32'd1);
    end
    step();
    check("t2_idle", 32'(score_valid), 32'd0);
    check("t2_drop", 32'(drop_count), 32'd0);

    // backpressure with a held output
    do_reset();
    score_ready = 1'b0;
    song_time = 16'd500;
    set_mt(7, 16'd495);
    match_trigger[7] = 1'b1;
    push(6'd7, 16'd5);
    step();
    match_trigger = '0;
    step();
    song_time = 16'd600;
    for (int i = 0; i < 10; i++) begin
      match_trigger = '0;
      if (i == 2) begin
        set_mt(7, 16'd590);
        match_trigger[7] = 1'b1;
        push(6'd7, 16'd10);
      end
      if (i == 5) begin
        set_mt(7, 16'd100);
        match_trigger[7] = 1'b1;
      end
      step();
      check("t3_hold_v", 32'(score_valid), 32'd1);
      check("t3_hold_n", 32'(score_note), 32'd7);
      check("t3_hold_dt", 32'(score_dt), 32'd5);
    end
    match_trigger = '0;
    check("t3_drop", 32'(drop_count), 32'd1);
    score_ready = 1'b1;
    drain();

    // fairness between two constantly retriggering notes
    do_reset();
    song_time = 16'd2000;
    set_mt(1, 16'd1990);
    set_mt(2, 16'd1980);
    match_trigger[1] = 1'b1;
    match_trigger[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(6'd1, 16'd10);
      push(6'd2, 16'd20);
    end
    for (int i = 0; i < 7; i++) step();
    match_trigger = '0;
    drain();
    check("t4_drop", 32'(drop_count), 32'd6);

    // wrap-around and stale boundaries
    do_reset();
    song_time = 16'h0003;
    set_mt(10, 16'hFFFE);
    match_trigger[10] = 1'b1;
    push(6'd10, 16'd5);
    step();
    match_trigger = '0;
    drain();
    song_time = 16'd3000;
    set_mt(11, 16'd0);
    match_trigger[11] = 1'b1;
    step();
    match_trigger = '0;
    step();
    check("t5_stale_v", 32'(score_valid), 32'd0);
    check("t5_stale1", 32'(stale_count), 32'd1);
    song_time = 16'd1000;
    set_mt(12, 16'd3000);
    match_trigger[12] = 1'b1;
    push(6'd12, 16'hF830);
    step();
    match_trigger = '0;
    drain();
    song_time = 16'd2001;
    set_mt(13, 16'd0);
    match_trigger[13] = 1'b1;
    step();
    match_trigger = '0;
    step();
    check("t5_edge_v", 32'(score_valid), 32'd0);
    check("t5_stale2", 32'(stale_count), 32'd2);

    // reset with events pending and an output held
    do_reset();
    score_ready = 1'b0;
    song_time = 16'd100;
    for (int i = 20; i < 24; i++) begin
      set_mt(i, 16'd100);
      match_trigger[i] = 1'b1;
    end
    step();
    match_trigger = '0;
    match_trigger[21] = 1'b1;
    step();
    match_trigger = '0;
    check("t6_pre_v", 32'(score_valid), 32'd1);
    check("t6_pre_drop", 32'(drop_count), 32'd1);
    do_reset();
    check("t6_valid", 32'(score_valid), 32'd0);
    check("t6_drop", 32'(drop_count), 32'd0);
    check("t6_stale", 32'(stale_count), 32'd0);
    score_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t6_quiet", 32'(score_valid), 32'd0);
    end
    check("leftover", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
